// File: rtl/riscv_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the FSM encoding and the writeback defaults.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      HELD  = 2'b01,
      FORCE = 2'b10
   } wb_state_t;

   localparam int WB_STARVE_LIMIT = 4;
   localparam int REG_X0          = 0;

endpackage

// File: rtl/riscv_wb_holdbuf.sv
// One-entry holding register for a deferred mul/div result.
// Load takes priority over clear.
module riscv_wb_holdbuf #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] load_rd,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  valid,
   output logic [ADDR_WIDTH-1:0] rd,
   output logic [DATA_WIDTH-1:0] data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         rd    <= '0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         rd    <= load_rd;
         data  <= load_data;
      end else if (clear) begin
         valid <= 1'b0;
         rd    <= '0;
         data  <= '0;
      end
   end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback first,
// mul/div results parked and force-drained after STARVE_LIMIT.
module riscv_wb_arbiter
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_wb_valid,
   input  logic [ADDR_WIDTH-1:0] pipe_rd,
   input  logic [DATA_WIDTH-1:0] pipe_wb_data,
   output logic                  pipe_stall,
   input  logic                  md_valid,
   input  logic [ADDR_WIDTH-1:0] md_rd,
   input  logic [DATA_WIDTH-1:0] md_data,
   output logic                  md_ready,
   output logic                  rf_we,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_X0);
   localparam logic [3:0] CNT_MAX = 4'(STARVE_LIMIT - 1);

   wb_state_t             state, state_nx;
   logic [3:0]            wait_cnt, cnt_nx, cnt_inc;
   logic                  p, m;
   logic                  buf_load, buf_clr, buf_valid;
   logic [ADDR_WIDTH-1:0] buf_rd;
   logic [DATA_WIDTH-1:0] buf_data;
   logic                  win;
   logic [ADDR_WIDTH-1:0] win_rd;
   logic [DATA_WIDTH-1:0] win_data;

   // Writes to x0 are no-ops and never take the port.
   assign p = pipe_wb_valid & (pipe_rd != X0);
   assign m = md_valid & (md_rd != X0);

   assign md_ready   = (state == IDLE) & ~rst;
   assign pipe_stall = (state == FORCE) & ~rst;

   riscv_wb_holdbuf #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_holdbuf (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .clear    (buf_clr),
      .load_rd  (md_rd),
      .load_data(md_data),
      .valid    (buf_valid),
      .rd       (buf_rd),
      .data     (buf_data)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = wait_cnt;
      cnt_inc  = wait_cnt + 4'd1;
      buf_load = 1'b0;
      buf_clr  = 1'b0;
      win      = 1'b0;
      win_rd   = '0;
      win_data = '0;
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            if (p) begin
               win      = 1'b1;
               win_rd   = pipe_rd;
               win_data = pipe_wb_data;
               if (m) begin
                  buf_load = 1'b1;
                  state_nx = HELD;
               end
            end else if (m) begin
               win      = 1'b1;
               win_rd   = md_rd;
               win_data = md_data;
            end
         end
         HELD: begin
            if (!p) begin
               win      = buf_valid;
               win_rd   = buf_rd;
               win_data = buf_data;
               buf_clr  = 1'b1;
               state_nx = IDLE;
            end else begin
               win      = 1'b1;
               win_rd   = pipe_rd;
               win_data = pipe_wb_data;
               // Younger pipeline write to same rd supersedes the buffer.
               if (pipe_rd == buf_rd) begin
                  buf_clr  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc >= CNT_MAX) state_nx = FORCE;
               end
            end
         end
         FORCE: begin
            win      = buf_valid;
            win_rd   = buf_rd;
            win_data = buf_data;
            buf_clr  = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= cnt_nx;
         rf_we    <= win;
         rf_waddr <= win_rd;
         rf_wdata <= win_data;
      end
   end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_riscv_wb_arbiter;

   localparam int LIMIT = 4;

   logic        clk, rst;
   logic        pipe_wb_valid, md_valid;
   logic [4:0]  pipe_rd, md_rd;
   logic [31:0] pipe_wb_data, md_data;
   logic        pipe_stall, md_ready, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t hq[$];
   int   m_age = 0;
   bit   m_force = 0;

   riscv_wb_arbiter #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_wb_valid(pipe_wb_valid),
      .pipe_rd      (pipe_rd),
      .pipe_wb_data (pipe_wb_data),
      .pipe_stall   (pipe_stall),
      .md_valid     (md_valid),
      .md_rd        (md_rd),
      .md_data      (md_data),
      .md_ready     (md_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: drive, check handshake outputs mid-cycle,
   // advance the model, then check the registered write.
   task automatic cyc(input logic r, input logic pv,
                      input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mrd,
                      input logic [31:0] md);
      bit          e_rdy, e_stl, e_we, p, mm;
      logic [4:0]  e_a;
      logic [31:0] e_d;
      rst = r;
      pipe_wb_valid = pv; pipe_rd = prd; pipe_wb_data = pd;
      md_valid = mv; md_rd = mrd; md_data = md;
      #3;
      e_rdy = !r && hq.size() == 0;
      e_stl = !r && m_force;
      checks++;
      if (md_ready !== e_rdy) begin
         errors++;
         $display("FAIL md_ready t=%0t got %b exp %b", $time, md_ready, e_rdy);
      end
      checks++;
      if (pipe_stall !== e_stl) begin
         errors++;
         $display("FAIL pipe_stall t=%0t got %b exp %b", $time, pipe_stall, e_stl);
      end
      p  = pv && prd != 0;
      mm = mv && mrd != 0;
      e_we = 0; e_a = 0; e_d = 0;
      if (r) begin
         hq.delete(); m_force = 0; m_age = 0;
      end else if (m_force) begin
         e_we = 1; e_a = hq[0].rd; e_d = hq[0].data;
         hq.delete(); m_force = 0;
      end else if (hq.size() == 0) begin
         if (p) begin
            e_we = 1; e_a = prd; e_d = pd;
            if (mm) begin
               hq.push_back('{mrd, md});
               m_age = 0;
            end
         end else if (mm) begin
            e_we = 1; e_a = mrd; e_d = md;
         end
      end else if (!p) begin
         e_we = 1; e_a = hq[0].rd; e_d = hq[0].data;
         hq.delete();
      end else begin
         e_we = 1; e_a = prd; e_d = pd;
         if (prd == hq[0].rd) hq.delete();
         else begin
            m_age++;
            if (m_age >= LIMIT - 1) m_force = 1;
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (rf_we !== e_we ||
          (e_we && (rf_waddr !== e_a || rf_wdata !== e_d))) begin
         errors++;
         $display("FAIL rf_write t=%0t got %b/%0d/%h exp %b/%0d/%h",
                  $time, rf_we, rf_waddr, rf_wdata, e_we, e_a, e_d);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_rf got %b/%0d/%h exp 0/0/0", rf_we, rf_waddr, rf_wdata);
      end
      idle(1);
      checks++;
      if (md_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b exp 1", md_ready);
      end
   endtask

   task automatic test_solo;
      cyc(0, 1, 3, 32'h11, 0, 0, 0);
      checks++;
      if (rf_we !== 1 || rf_waddr !== 3 || rf_wdata !== 32'h11) begin
         errors++;
         $display("FAIL solo_pipe got %0d/%h exp 3/11", rf_waddr, rf_wdata);
      end
      cyc(0, 0, 0, 0, 1, 7, 32'h22);
      checks++;
      if (rf_we !== 1 || rf_waddr !== 7 || rf_wdata !== 32'h22) begin
         errors++;
         $display("FAIL solo_md got %0d/%h exp 7/22", rf_waddr, rf_wdata);
      end
      idle(1);
   endtask

   task automatic test_collision;
      cyc(0, 1, 5, 32'hA, 1, 9, 32'hB);
      checks++;
      if (md_ready !== 1'b0) begin
         errors++;
         $display("FAIL coll_ready got %b exp 0", md_ready);
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (rf_waddr !== 9 || rf_wdata !== 32'hB) begin
         errors++;
         $display("FAIL coll_drain got %0d/%h exp 9/b", rf_waddr, rf_wdata);
      end
      idle(1);
   endtask

   task automatic test_starve;
      cyc(0, 1, 5, 32'hA, 1, 9, 32'hB);
      cyc(0, 1, 1, 32'h101, 0, 0, 0);
      cyc(0, 1, 2, 32'h102, 0, 0, 0);
      cyc(0, 1, 3, 32'h103, 0, 0, 0);
      checks++;
      if (pipe_stall !== 1'b1) begin
         errors++;
         $display("FAIL starve_stall got %b exp 1", pipe_stall);
      end
      cyc(0, 1, 4, 32'h104, 0, 0, 0);
      checks++;
      if (rf_waddr !== 9 || rf_wdata !== 32'hB) begin
         errors++;
         $display("FAIL starve_drain got %0d/%h exp 9/b", rf_waddr, rf_wdata);
      end
      cyc(0, 1, 4, 32'h104, 0, 0, 0);
      checks++;
      if (rf_waddr !== 4 || rf_wdata !== 32'h104) begin
         errors++;
         $display("FAIL starve_replay got %0d/%h exp 4/104", rf_waddr, rf_wdata);
      end
      idle(1);
   endtask

   task automatic test_waw;
      cyc(0, 1, 5, 32'hA, 1, 9, 32'hB);
      cyc(0, 1, 9, 32'hC, 0, 0, 0);
      checks++;
      if (rf_waddr !== 9 || rf_wdata !== 32'hC) begin
         errors++;
         $display("FAIL waw_write got %0d/%h exp 9/c", rf_waddr, rf_wdata);
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (rf_we !== 1'b0 || md_ready !== 1'b1) begin
         errors++;
         $display("FAIL waw_drop got we=%b rdy=%b exp 0/1", rf_we, md_ready);
      end
   endtask

   task automatic test_x0_and_reset;
      cyc(0, 1, 6, 32'h66, 1, 0, 32'hDEAD);
      cyc(0, 0, 0, 0, 1, 0, 32'hBEEF);
      checks++;
      if (rf_we !== 1'b0) begin
         errors++;
         $display("FAIL x0_md got we=%b exp 0", rf_we);
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 5, 32'hA, 1, 9, 32'hB);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (rf_we !== 1'b0 || md_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got we=%b rdy=%b exp 0/1", rf_we, md_ready);
      end
   endtask

   task automatic test_random;
      logic        r, pv, mv;
      logic [4:0]  prd, mrd;
      logic [31:0] pd, md;
      pv = 0; mv = 0; prd = 0; mrd = 0; pd = 0; md = 0;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(99) < 2);
         if (!m_force) begin
            pv  = ($urandom_range(99) < 70);
            prd = 5'($urandom_range(7));
            pd  = $urandom;
         end
         if (hq.size() == 0 || !mv) begin
            mv  = ($urandom_range(99) < 45);
            mrd = 5'($urandom_range(7));
            md  = $urandom;
         end
         cyc(r, pv, prd, pd, mv, mrd, md);
      end
      idle(2);
   endtask

   initial begin
      rst = 1;
      pipe_wb_valid = 0; pipe_rd = 0; pipe_wb_data = 0;
      md_valid = 0; md_rd = 0; md_data = 0;
      @(posedge clk);
      #1;
      test_reset;
      test_solo;
      test_collision;
      test_starve;
      test_waw;
      test_x0_and_reset;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
